// File: rtl/mem_responder_pkg.sv
// rtl/mem_responder_pkg.sv - shared access-size and state encodings for the memory request interface
package mem_responder_pkg;

    localparam int MEM_SIZE_WIDTH  = 2;
    localparam int MEM_LATENCY_MAX = 15;

    localparam logic [MEM_SIZE_WIDTH-1:0] MEM_SIZE_BYTE = 2'b00;
    localparam logic [MEM_SIZE_WIDTH-1:0] MEM_SIZE_HALF = 2'b01;
    localparam logic [MEM_SIZE_WIDTH-1:0] MEM_SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        MEM_STATE_IDLE    = 2'd0,
        MEM_STATE_WAIT    = 2'd1,
        MEM_STATE_RESPOND = 2'd2
    } mem_state_e;

    // Size 11 is treated as misaligned so it errors through the same path.
    function automatic logic mem_misaligned(input logic [MEM_SIZE_WIDTH-1:0] size,
                                            input logic [1:0] addr_lo);
        case (size)
            MEM_SIZE_BYTE: mem_misaligned = 1'b0;
            MEM_SIZE_HALF: mem_misaligned = addr_lo[0];
            MEM_SIZE_WORD: mem_misaligned = (addr_lo != 2'b00);
            default:       mem_misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_byte_lane.sv
// rtl/mem_byte_lane.sv - byte enables, store replication and load extraction/extension per access size
module mem_byte_lane
    import mem_responder_pkg::*;
(
    input  logic [MEM_SIZE_WIDTH-1:0] size,
    input  logic [1:0]                addr_lo,
    input  logic                      is_unsigned,
    input  logic [31:0]               wdata,
    input  logic [31:0]               rword,
    output logic [3:0]                byte_en,
    output logic [31:0]               wdata_rep,
    output logic [31:0]               rdata_ext
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    always_comb begin
        byte_en   = 4'b0000;
        wdata_rep = wdata;
        rdata_ext = 32'h0;
        rbyte     = rword[{addr_lo, 3'b000} +: 8];
        rhalf     = addr_lo[1] ? rword[31:16] : rword[15:0];
        case (size)
            MEM_SIZE_BYTE: begin
                byte_en   = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {{24{~is_unsigned & rbyte[7]}}, rbyte};
            end
            MEM_SIZE_HALF: begin
                byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = {{16{~is_unsigned & rhalf[15]}}, rhalf};
            end
            MEM_SIZE_WORD: begin
                byte_en   = 4'b1111;
                rdata_ext = rword;
            end
            default: begin
                byte_en = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - fixed-latency memory responder with word array and byte/half/word access
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      memReq,
    input  logic                      memWrite,
    input  logic [1:0]                memSize,
    input  logic                      memUnsigned,
    input  logic [31:0]               memAddr,
    input  logic [DATA_WIDTH-1:0]     memWData,
    output logic                      memBusy,
    output logic                      memReady,
    output logic [DATA_WIDTH-1:0]     memRData,
    output logic                      memError
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    logic [DATA_WIDTH-1:0] mem_array [DEPTH_WORDS];

    mem_state_e            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  write_q, write_d;
    logic [1:0]            size_q, size_d;
    logic                  unsigned_q, unsigned_d;
    logic [IDX_W+1:0]      addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  busy_q, busy_d;
    logic                  ready_q, ready_d;
    logic                  error_q, error_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic                  mem_we;
    logic [3:0]            lane_be;
    logic [DATA_WIDTH-1:0] lane_wdata;
    logic [DATA_WIDTH-1:0] lane_rdata;
    logic                  unused_addr;

    assign unused_addr = ^memAddr[31:IDX_W+2];

    mem_byte_lane u_lane (
        .size        (size_q),
        .addr_lo     (addr_q[1:0]),
        .is_unsigned (unsigned_q),
        .wdata       (wdata_q),
        .rword       (mem_array[addr_q[IDX_W+1:2]]),
        .byte_en     (lane_be),
        .wdata_rep   (lane_wdata),
        .rdata_ext   (lane_rdata)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        write_d    = write_q;
        size_d     = size_q;
        unsigned_d = unsigned_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        busy_d     = busy_q;
        ready_d    = 1'b0;
        error_d    = 1'b0;
        rdata_d    = '0;
        mem_we     = 1'b0;
        case (state_q)
            MEM_STATE_WAIT: begin
                busy_d = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = MEM_STATE_RESPOND;
                    ready_d = 1'b1;
                    error_d = mem_misaligned(size_q, addr_q[1:0]);
                    if (!error_d) begin
                        mem_we  = write_q;
                        rdata_d = write_q ? '0 : lane_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                // The edge closing RESPOND may already accept the next request.
                if (memReq) begin
                    state_d    = MEM_STATE_WAIT;
                    cnt_d      = 4'(LATENCY - 1);
                    write_d    = memWrite;
                    size_d     = memSize;
                    unsigned_d = memUnsigned;
                    addr_d     = memAddr[IDX_W+1:0];
                    wdata_d    = memWData;
                    busy_d     = 1'b1;
                end else begin
                    state_d = MEM_STATE_IDLE;
                    busy_d  = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= MEM_STATE_IDLE;
            cnt_q      <= 4'd0;
            write_q    <= 1'b0;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
            error_q    <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            write_q    <= write_d;
            size_q     <= size_d;
            unsigned_q <= unsigned_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
            error_q    <= error_d;
            rdata_q    <= rdata_d;
        end
    end

    // Array is deliberately outside reset so contents survive rst.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (mem_we && lane_be[i]) begin
                mem_array[addr_q[IDX_W+1:2]][8*i +: 8] <= lane_wdata[8*i +: 8];
            end
        end
    end

    assign memBusy  = busy_q;
    assign memReady = ready_q;
    assign memError = error_q;
    assign memRData = rdata_q;

endmodule
